// File: rtl/keyboard_fifo_pkg.sv
// -----------------------------------------------------------------------------
// keyboard_pkg
// Shared constants for the keypad event FIFO: register addresses, STATUS and
// CONTROL bit positions, the value returned by a DATA read of an empty FIFO,
// and a helper that packs the STATUS word.
// -----------------------------------------------------------------------------
package keyboard_pkg;

  // Register map
  localparam logic [2:0] KBD_DATA   = 3'b000;
  localparam logic [2:0] KBD_STATUS = 3'b010;
  localparam logic [2:0] KBD_CTRL   = 3'b100;

  // STATUS bit positions
  localparam int ST_NOT_EMPTY = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_IRQ_EN    = 3;
  localparam int ST_COUNT_LSB = 4;

  // CONTROL bit positions (write side)
  localparam int CTRL_FLUSH   = 0;
  localparam int CTRL_CLR_OVF = 1;
  localparam int CTRL_IRQ_EN  = 2;

  // DATA read result when nothing is buffered (empty flag in bit 15)
  localparam logic [15:0] EMPTY_READ = 16'h8000;

  // Pack the STATUS register; bit0 keeps the scanner's "key present" meaning.
  function automatic logic [15:0] status_word(
    input logic [3:0] cnt,
    input logic       irq_en,
    input logic       overflow,
    input logic       full,
    input logic       not_empty
  );
    status_word = {8'h00, cnt, irq_en, overflow, full, not_empty};
  endfunction

endpackage

// File: rtl/keyboard_fifo_if.sv
// -----------------------------------------------------------------------------
// keyboard_fifo_if
// Bundles the scanner inputs and the CPU register bus of the keypad FIFO.
//   key_valid        scanner key-present level (asynchronous)
//   key_code         decoded key, stable while key_valid is high
//   read_enable      CPU read strobe, one cycle per access
//   write_enable     CPU write strobe, one cycle per access
//   address          register select
//   write_data       CPU write data
//   read_data_output CPU read data (combinational)
//   interrupt        FIFO non-empty and interrupts enabled
// master: scanner/CPU side, slave: the FIFO.
// -----------------------------------------------------------------------------
interface keyboard_fifo_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        read_enable;
  logic        write_enable;
  logic [2:0]  address;
  logic [15:0] write_data;
  logic [15:0] read_data_output;
  logic        interrupt;

  modport master (
    output key_valid, key_code, read_enable, write_enable, address, write_data,
    input  read_data_output, interrupt
  );

  modport slave (
    input  key_valid, key_code, read_enable, write_enable, address, write_data,
    output read_data_output, interrupt
  );
endinterface

// File: rtl/keyboard_fifo_sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
// Two-flop synchronizer for an asynchronous level followed by a rising-edge
// detector. pulse_o is high for exactly one clock per low-to-high transition
// of the synchronized level.
//   clock_i   clock
//   reset_ni  asynchronous active-low reset
//   async_i   asynchronous level input
//   pulse_o   single-cycle rising-edge pulse
// Clearing the history flop on reset makes a level that is already high when
// reset releases look like a fresh rising edge.
// -----------------------------------------------------------------------------
module sync_edge (
  input  logic clock_i,
  input  logic reset_ni,
  input  logic async_i,
  output logic pulse_o
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  // Synchronizer chain plus one flop of history for edge detection.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= async_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign pulse_o = s2_q & ~s3_q;

endmodule

// File: rtl/keyboard_fifo.sv
// -----------------------------------------------------------------------------
// keyboard_fifo
// Buffers key presses from the 4x4 keypad scanner so software can collect
// them through memory-mapped registers instead of polling every press.
//   clock  system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    keyboard_fifo_if.slave: scanner inputs, CPU register bus,
//          read data and interrupt
// Registers: DATA (read pops), STATUS (read only), CONTROL (flush, clear
// overflow, interrupt enable). Unmapped addresses read 0 and ignore writes.
// -----------------------------------------------------------------------------
module keyboard_fifo
  import keyboard_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input logic           clock,
  input logic           reset,
  keyboard_fifo_if.slave bus
);

  logic             press_s;
  logic [3:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    rd_ptr_d;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic             overflow_q;
  logic             overflow_d;
  logic             irq_en_q;
  logic             irq_en_d;

  logic             empty_s;
  logic             full_s;
  logic             ctrl_wr_s;
  logic             flush_s;
  logic             pop_s;
  logic             push_s;
  logic             drop_s;
  logic [3:0]       count4_s;
  logic [15:0]      rdata_s;
  logic             unused_wdata_s;

  sync_edge u_sync_edge (
    .clock_i  (clock),
    .reset_ni (reset),
    .async_i  (bus.key_valid),
    .pulse_o  (press_s)
  );

  assign empty_s   = (count_q == {(AW+1){1'b0}});
  assign full_s    = (count_q == (AW+1)'(DEPTH));
  assign ctrl_wr_s = bus.write_enable & (bus.address == KBD_CTRL);
  assign flush_s   = ctrl_wr_s & bus.write_data[CTRL_FLUSH];

  // A simultaneous write wins the bus, so a read only pops without one.
  assign pop_s  = bus.read_enable & ~bus.write_enable
                & (bus.address == KBD_DATA) & ~empty_s;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign push_s = press_s & ~flush_s & (~full_s | pop_s);
  assign drop_s = press_s & ~flush_s & full_s & ~pop_s;

  assign count4_s       = 4'(count_q);
  assign unused_wdata_s = ^bus.write_data[15:3];

  // Next-state for pointers, occupancy, overflow flag and interrupt enable.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    irq_en_d   = irq_en_q;

    if (flush_s) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end

    // A dropped key in the same cycle as a clear still leaves the flag set.
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (ctrl_wr_s && bus.write_data[CTRL_CLR_OVF]) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end

    if (ctrl_wr_s) begin
      irq_en_d = bus.write_data[CTRL_IRQ_EN];
    end else begin
      irq_en_d = irq_en_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      count_q    <= {(AW+1){1'b0}};
      overflow_q <= 1'b0;
      irq_en_q   <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      irq_en_q   <= irq_en_d;
    end
  end

  // Key storage; written only when a push is accepted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 4'h0;
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= bus.key_code;
    end
  end

  // Register read mux; the bus is quiet whenever no read is in progress.
  always_comb begin
    rdata_s = 16'h0000;
    if (bus.read_enable) begin
      case (bus.address)
        KBD_DATA: begin
          if (empty_s) begin
            rdata_s = EMPTY_READ;
          end else begin
            rdata_s = {1'b0, 11'h000, mem_q[rd_ptr_q]};
          end
        end
        KBD_STATUS: rdata_s = status_word(count4_s, irq_en_q, overflow_q,
                                          full_s, ~empty_s);
        KBD_CTRL:   rdata_s = {13'h0000, irq_en_q, 2'b00};
        default:    rdata_s = 16'h0000;
      endcase
    end else begin
      rdata_s = 16'h0000;
    end
  end

  assign bus.read_data_output = rdata_s;
  assign bus.interrupt        = ~empty_s & irq_en_q;

endmodule

// File: tb/tb_keyboard_fifo.sv
module tb_keyboard_fifo;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;

  keyboard_fifo_if bus_if ();

  keyboard_fifo #(.DEPTH(8), .AW(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required end of test first");
    $fatal(1, "watchdog");
  end

  // One clock; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Side-effect-free combinational look at a register between edges.
  task automatic peek(input logic [2:0] addr, output logic [15:0] d);
    bus_if.address     = addr;
    bus_if.read_enable = 1'b1;
    #1;
    d = bus_if.read_data_output;
    bus_if.read_enable = 1'b0;
  endtask

  // Full read access committed on the next edge.
  task automatic cpu_read(input logic [2:0] addr, output logic [15:0] d);
    bus_if.address     = addr;
    bus_if.read_enable = 1'b1;
    #1;
    d = bus_if.read_data_output;
    tick();
    bus_if.read_enable = 1'b0;
  endtask

  task automatic cpu_write(input logic [2:0] addr, input logic [15:0] wd);
    bus_if.address      = addr;
    bus_if.write_data   = wd;
    bus_if.write_enable = 1'b1;
    tick();
    bus_if.write_enable = 1'b0;
  endtask

  task automatic press_key(input logic [3:0] code, input int hold);
    bus_if.key_code  = code;
    bus_if.key_valid = 1'b1;
    repeat (hold) tick();
    bus_if.key_valid = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    logic [15:0] d;
    n_checks++;
    if (bus_if.interrupt !== 1'b0) begin
      n_fail++; $display("FAIL reset_irq: got %b want 0", bus_if.interrupt);
    end
    peek(3'b010, d);
    n_checks++;
    if (d !== 16'h0008) begin
      n_fail++; $display("FAIL reset_status: got %h want 0008", d);
    end
    peek(3'b000, d);
    n_checks++;
    if (d !== 16'h8000) begin
      n_fail++; $display("FAIL reset_data: got %h want 8000", d);
    end
    peek(3'b100, d);
    n_checks++;
    if (d !== 16'h0004) begin
      n_fail++; $display("FAIL reset_ctrl: got %h want 0004", d);
    end
    #1;
    n_checks++;
    if (bus_if.read_data_output !== 16'h0000) begin
      n_fail++; $display("FAIL idle_rdata: got %h want 0000", bus_if.read_data_output);
    end
    tick();
    reset = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_single_press();
    logic [15:0] d;
    bus_if.key_code  = 4'h7;
    bus_if.key_valid = 1'b1;
    repeat (2) tick();
    peek(3'b010, d);
    n_checks++;
    if (d !== 16'h0008) begin
      n_fail++; $display("FAIL latency_2edges: got %h want 0008", d);
    end
    tick();
    peek(3'b010, d);
    n_checks++;
    if (d !== 16'h0019) begin
      n_fail++; $display("FAIL latency_3edges: got %h want 0019", d);
    end
    n_checks++;
    if (bus_if.interrupt !== 1'b1) begin
      n_fail++; $display("FAIL press_irq: got %b want 1", bus_if.interrupt);
    end
    repeat (17) tick();
    peek(3'b010, d);
    n_checks++;
    if (d !== 16'h0019) begin
      n_fail++; $display("FAIL held_one_push: got %h want 0019", d);
    end
    bus_if.key_valid = 1'b0;
    repeat (3) tick();
    cpu_read(3'b000, d);
    n_checks++;
    if (d !== 16'h0007) begin
      n_fail++; $display("FAIL single_data: got %h want 0007", d);
    end
    peek(3'b010, d);
    n_checks++;
    if (d !== 16'h0008) begin
      n_fail++; $display("FAIL after_pop_status: got %h want 0008", d);
    end
    n_checks++;
    if (bus_if.interrupt !== 1'b0) begin
      n_fail++; $display("FAIL after_pop_irq: got %b want 0", bus_if.interrupt);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] d;
    for (int i = 1; i <= 9; i++) press_key(4'(i), 4);
    peek(3'b010, d);
    n_checks++;
    if (d !== 16'h008F) begin
      n_fail++; $display("FAIL overflow_status: got %h want 008f", d);
    end
    for (int i = 1; i <= 8; i++) begin
      cpu_read(3'b000, d);
      n_checks++;
      if (d !== 16'(i)) begin
        n_fail++; $display("FAIL order_read%0d: got %h want %h", i, d, 16'(i));
      end
    end
    cpu_read(3'b000, d);
    n_checks++;
    if (d !== 16'h8000) begin
      n_fail++; $display("FAIL ninth_read: got %h want 8000", d);
    end
    peek(3'b010, d);
    n_checks++;
    if (d !== 16'h000C) begin
      n_fail++; $display("FAIL sticky_ovf: got %h want 000c", d);
    end
    cpu_write(3'b100, 16'h0006);
    peek(3'b010, d);
    n_checks++;
    if (d !== 16'h0008) begin
      n_fail++; $display("FAIL clear_ovf: got %h want 0008", d);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d;
    // Full FIFO: push lands on the same edge as a pop.
    for (int i = 1; i <= 8; i++) press_key(4'(i), 4);
    bus_if.key_code  = 4'hA;
    bus_if.key_valid = 1'b1;
    repeat (2) tick();
    cpu_read(3'b000, d);
    n_checks++;
    if (d !== 16'h0001) begin
      n_fail++; $display("FAIL full_pop_value: got %h want 0001", d);
    end
    bus_if.key_valid = 1'b0;
    repeat (3) tick();
    peek(3'b010, d);
    n_checks++;
    if (d !== 16'h008B) begin
      n_fail++; $display("FAIL full_push_pop_status: got %h want 008b", d);
    end
    for (int i = 2; i <= 9; i++) begin
      cpu_read(3'b000, d);
      n_checks++;
      if (d !== ((i == 9) ? 16'h000A : 16'(i))) begin
        n_fail++; $display("FAIL full_drain%0d: got %h", i, d);
      end
    end
    // Empty FIFO: the pop is ignored, the push is taken.
    bus_if.key_code  = 4'h3;
    bus_if.key_valid = 1'b1;
    repeat (2) tick();
    cpu_read(3'b000, d);
    n_checks++;
    if (d !== 16'h8000) begin
      n_fail++; $display("FAIL empty_pop_value: got %h want 8000", d);
    end
    bus_if.key_valid = 1'b0;
    repeat (3) tick();
    peek(3'b010, d);
    n_checks++;
    if (d !== 16'h0019) begin
      n_fail++; $display("FAIL empty_push_pop_status: got %h want 0019", d);
    end
    // Read and write strobes together: the DATA read must not pop.
    bus_if.address      = 3'b000;
    bus_if.write_data   = 16'h0001;
    bus_if.read_enable  = 1'b1;
    bus_if.write_enable = 1'b1;
    tick();
    bus_if.read_enable  = 1'b0;
    bus_if.write_enable = 1'b0;
    peek(3'b010, d);
    n_checks++;
    if (d !== 16'h0019) begin
      n_fail++; $display("FAIL rd_wr_conflict: got %h want 0019", d);
    end
    cpu_read(3'b000, d);
    n_checks++;
    if (d !== 16'h0003) begin
      n_fail++; $display("FAIL empty_push_data: got %h want 0003", d);
    end
  endtask

  task automatic test_control();
    logic [15:0] d;
    for (int i = 1; i <= 9; i++) press_key(4'(i), 4);
    for (int i = 1; i <= 5; i++) cpu_read(3'b000, d);
    peek(3'b010, d);
    n_checks++;
    if (d !== 16'h003D) begin
      n_fail++; $display("FAIL three_left_status: got %h want 003d", d);
    end
    cpu_write(3'b100, 16'h0003);
    peek(3'b010, d);
    n_checks++;
    if (d !== 16'h0000) begin
      n_fail++; $display("FAIL flush_clear_status: got %h want 0000", d);
    end
    peek(3'b100, d);
    n_checks++;
    if (d !== 16'h0000) begin
      n_fail++; $display("FAIL ctrl_readback: got %h want 0000", d);
    end
    press_key(4'h5, 4);
    peek(3'b010, d);
    n_checks++;
    if (d !== 16'h0011) begin
      n_fail++; $display("FAIL irq_off_status: got %h want 0011", d);
    end
    n_checks++;
    if (bus_if.interrupt !== 1'b0) begin
      n_fail++; $display("FAIL irq_off: got %b want 0", bus_if.interrupt);
    end
    cpu_read(3'b000, d);
    n_checks++;
    if (d !== 16'h0005) begin
      n_fail++; $display("FAIL irq_off_data: got %h want 0005", d);
    end
    cpu_write(3'b100, 16'h0004);
    // Flush on the same edge as a push: flush wins.
    bus_if.key_code  = 4'hE;
    bus_if.key_valid = 1'b1;
    repeat (2) tick();
    cpu_write(3'b100, 16'h0005);
    bus_if.key_valid = 1'b0;
    repeat (3) tick();
    peek(3'b010, d);
    n_checks++;
    if (d !== 16'h0008) begin
      n_fail++; $display("FAIL flush_vs_push: got %h want 0008", d);
    end
    // Flush alone leaves overflow set; unmapped writes are ignored.
    for (int i = 1; i <= 9; i++) press_key(4'(i), 4);
    cpu_write(3'b111, 16'h0007);
    cpu_write(3'b100, 16'h0005);
    peek(3'b010, d);
    n_checks++;
    if (d !== 16'h000C) begin
      n_fail++; $display("FAIL flush_keeps_ovf: got %h want 000c", d);
    end
    cpu_write(3'b100, 16'h0006);
    peek(3'b110, d);
    n_checks++;
    if (d !== 16'h0000) begin
      n_fail++; $display("FAIL unmapped_read: got %h want 0000", d);
    end
  endtask

  task automatic test_reset_midop();
    logic [15:0] d;
    press_key(4'h1, 4);
    press_key(4'h2, 4);
    peek(3'b010, d);
    n_checks++;
    if (d !== 16'h0029) begin
      n_fail++; $display("FAIL two_entries: got %h want 0029", d);
    end
    bus_if.key_code  = 4'hC;
    bus_if.key_valid = 1'b1;
    tick();
    reset = 1'b0;
    peek(3'b010, d);
    n_checks++;
    if (d !== 16'h0008) begin
      n_fail++; $display("FAIL async_reset_status: got %h want 0008", d);
    end
    n_checks++;
    if (bus_if.interrupt !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_irq: got %b want 0", bus_if.interrupt);
    end
    repeat (3) tick();
    reset = 1'b1;
    repeat (2) tick();
    peek(3'b010, d);
    n_checks++;
    if (d !== 16'h0008) begin
      n_fail++; $display("FAIL post_reset_2edges: got %h want 0008", d);
    end
    tick();
    peek(3'b010, d);
    n_checks++;
    if (d !== 16'h0019) begin
      n_fail++; $display("FAIL post_reset_push: got %h want 0019", d);
    end
    repeat (10) tick();
    bus_if.key_valid = 1'b0;
    repeat (3) tick();
    cpu_read(3'b000, d);
    n_checks++;
    if (d !== 16'h000C) begin
      n_fail++; $display("FAIL post_reset_data: got %h want 000c", d);
    end
    peek(3'b010, d);
    n_checks++;
    if (d !== 16'h0008) begin
      n_fail++; $display("FAIL post_reset_single: got %h want 0008", d);
    end
  endtask

  initial begin
    n_checks            = 0;
    n_fail              = 0;
    reset               = 1'b0;
    bus_if.key_valid    = 1'b0;
    bus_if.key_code     = 4'h0;
    bus_if.read_enable  = 1'b0;
    bus_if.write_enable = 1'b0;
    bus_if.address      = 3'b000;
    bus_if.write_data   = 16'h0000;
    tick();
    test_reset();
    test_single_press();
    test_overflow();
    test_back_to_back();
    test_control();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
